// File: rtl/stopwatch_mmss.sv
// -----------------------------------------------------------------------------
// stopwatch_mmss
//   Four-digit MM:SS stopwatch core. Raw active-low pushbuttons are conditioned
//   internally (two-flop sync, debounce, press detect), a small IDLE/RUN/PAUSE
//   FSM decides when the 1 Hz tick advances a BCD digit chain, and the four
//   digits are presented as 5-bit values ready for per-digit 7-segment decoders.
//
// Parameters
//   DEBOUNCE_CYCLES : clk cycles a synchronized key level must hold before it
//                     is accepted.
//   SEC_MAX_TENS    : top value of the seconds-tens and minutes-tens digits.
//
// Ports
//   clk          in   system clock
//   rst          in   synchronous, active-high reset
//   tick         in   one-clk count-enable pulse, once per second
//   key_start_n  in   raw start/stop button, active-low, asynchronous
//   key_clear_n  in   raw clear button, active-low, asynchronous
//   digit0..3    out  seconds units, seconds tens, minutes units, minutes tens
//   running      out  high while the FSM is in RUN
//   wrap         out  one-clk pulse when 59:59 rolls over to 00:00
//   dbg_state    out  current FSM state (0 IDLE, 1 RUN, 2 PAUSE) for checkers
//
// Every output is a register; nothing combinational reaches the pins.
// -----------------------------------------------------------------------------
module stopwatch_mmss #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SEC_MAX_TENS    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       key_start_n,
  input  logic       key_clear_n,
  output logic [4:0] digit0,
  output logic [4:0] digit1,
  output logic [4:0] digit2,
  output logic [4:0] digit3,
  output logic       running,
  output logic       wrap,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]    MAX_T    = 4'(SEC_MAX_TENS);

  // ---------------------------------------------------------------------------
  // Key conditioning. Index 0 = start, index 1 = clear.
  // The counter only runs while the synchronized level disagrees with the
  // accepted level, so any bounce back to the accepted level restarts it.
  // A press is emitted only on an accepted 1->0 change; releases are silent
  // and a held key cannot produce a second press.
  // ---------------------------------------------------------------------------
  logic [1:0]         w_key_n;
  logic [1:0]         r_sync1;
  logic [1:0]         r_sync2;
  logic [1:0]         r_deb;
  logic [1:0]         r_press;
  logic [1:0][CW-1:0] r_cnt;

  assign w_key_n = {key_clear_n, key_start_n};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 2'b11;
      r_sync2 <= 2'b11;
      r_deb   <= 2'b11;
      r_press <= 2'b00;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= w_key_n;
      r_sync2 <= r_sync1;
      for (int k = 0; k < 2; k++) begin
        r_press[k] <= 1'b0;
        if (r_sync2[k] == r_deb[k]) begin
          r_cnt[k] <= '0;
        end else if (r_cnt[k] == CNT_LAST) begin
          r_deb[k]   <= r_sync2[k];
          r_cnt[k]   <= '0;
          r_press[k] <= ~r_sync2[k];
        end else begin
          r_cnt[k] <= r_cnt[k] + CW'(1);
        end
      end
    end
  end

  logic w_start;
  logic w_clear;

  assign w_start = r_press[0];
  assign w_clear = r_press[1];

  // ---------------------------------------------------------------------------
  // BCD digit chain: next values assuming one more second is counted.
  // w_c3 marks the 59:59 -> 00:00 rollover.
  // ---------------------------------------------------------------------------
  logic [3:0] r_d0, r_d1, r_d2, r_d3;
  logic [3:0] w_n0, w_n1, w_n2, w_n3;
  logic       w_c0, w_c1, w_c2, w_c3;

  assign w_c0 = (r_d0 == 4'd9);
  assign w_c1 = w_c0 && (r_d1 == MAX_T);
  assign w_c2 = w_c1 && (r_d2 == 4'd9);
  assign w_c3 = w_c2 && (r_d3 == MAX_T);

  assign w_n0 = w_c0 ? 4'd0 : r_d0 + 4'd1;
  assign w_n1 = w_c0 ? (w_c1 ? 4'd0 : r_d1 + 4'd1) : r_d1;
  assign w_n2 = w_c1 ? (w_c2 ? 4'd0 : r_d2 + 4'd1) : r_d2;
  assign w_n3 = w_c2 ? (w_c3 ? 4'd0 : r_d3 + 4'd1) : r_d3;

  // ---------------------------------------------------------------------------
  // Control FSM with registered running/wrap and the digit registers.
  // Clear beats start in IDLE and PAUSE; in RUN clear is ignored and a tick
  // arriving with a start press is still counted on the way into PAUSE.
  // ---------------------------------------------------------------------------
  state_t r_state;
  logic   r_running;
  logic   r_wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_running <= 1'b0;
      r_wrap    <= 1'b0;
      r_d0      <= 4'd0;
      r_d1      <= 4'd0;
      r_d2      <= 4'd0;
      r_d3      <= 4'd0;
    end else begin
      r_wrap <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_clear) begin
            r_d0 <= 4'd0;
            r_d1 <= 4'd0;
            r_d2 <= 4'd0;
            r_d3 <= 4'd0;
          end else if (w_start) begin
            r_state   <= S_RUN;
            r_running <= 1'b1;
          end
        end
        S_RUN: begin
          if (tick) begin
            r_d0   <= w_n0;
            r_d1   <= w_n1;
            r_d2   <= w_n2;
            r_d3   <= w_n3;
            r_wrap <= w_c3;
          end
          if (w_start) begin
            r_state   <= S_PAUSE;
            r_running <= 1'b0;
          end
        end
        S_PAUSE: begin
          if (w_clear) begin
            r_state   <= S_IDLE;
            r_running <= 1'b0;
            r_d0      <= 4'd0;
            r_d1      <= 4'd0;
            r_d2      <= 4'd0;
            r_d3      <= 4'd0;
          end else if (w_start) begin
            r_state   <= S_RUN;
            r_running <= 1'b1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  assign digit0    = {1'b0, r_d0};
  assign digit1    = {1'b0, r_d1};
  assign digit2    = {1'b0, r_d2};
  assign digit3    = {1'b0, r_d3};
  assign running   = r_running;
  assign wrap      = r_wrap;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_stopwatch_mmss.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_mmss
//   Self-checking bench for stopwatch_mmss with a short debounce window.
//   Expected output words come from a seconds-count model (digits derived by
//   division/modulo) and are queued when stimulus is driven, then popped and
//   compared against the DUT outputs on the following falling edge.
//   Output word: {state[1:0], running, wrap, digit3, digit2, digit1, digit0}.
// -----------------------------------------------------------------------------
module tb_stopwatch_mmss;

  localparam int DB = 4;
  localparam int W  = 24;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       key_start_n = 1'b1;
  logic       key_clear_n = 1'b1;
  logic [4:0] digit0, digit1, digit2, digit3;
  logic       running, wrap;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  stopwatch_mmss #(
    .DEBOUNCE_CYCLES(DB),
    .SEC_MAX_TENS   (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .key_start_n(key_start_n),
    .key_clear_n(key_clear_n),
    .digit0     (digit0),
    .digit1     (digit1),
    .digit2     (digit2),
    .digit3     (digit3),
    .running    (running),
    .wrap       (wrap),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           n_vec = 0;
  int           n_err = 0;

  logic [1:0] m_state = ST_IDLE;
  int         m_secs  = 0;
  bit         m_wrap  = 1'b0;

  task automatic check_eq(input string tag, input logic [W-1:0] obs,
                          input logic [W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_vec(input logic [1:0] st, input int secs,
                                           input bit w);
    int mm, ss;
    mm = secs / 60;
    ss = secs % 60;
    return {st, (st == ST_RUN), w, 5'(mm / 10), 5'(mm % 10), 5'(ss / 10), 5'(ss % 10)};
  endfunction

  function automatic logic [W-1:0] obs_vec();
    return {dbg_state, running, wrap, digit3, digit2, digit1, digit0};
  endfunction

  task automatic push_model();
    exp_q.push_back(exp_vec(m_state, m_secs, m_wrap));
  endtask

  task automatic sb_check(input string tag);
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: got %h expected <empty queue>", tag, obs_vec());
    end else begin
      check_eq(tag, obs_vec(), exp_q.pop_front());
    end
  endtask

  // Reference behaviour for one clk edge with the given press/tick events.
  task automatic model_step(input bit s, input bit c, input bit t);
    m_wrap = 1'b0;
    case (m_state)
      ST_IDLE: begin
        if (c) m_secs = 0;
        else if (s) m_state = ST_RUN;
      end
      ST_RUN: begin
        if (t) begin
          if (m_secs == 3599) begin
            m_secs = 0;
            m_wrap = 1'b1;
          end else begin
            m_secs++;
          end
        end
        if (s) m_state = ST_PAUSE;
      end
      default: begin
        if (c) begin
          m_state = ST_IDLE;
          m_secs  = 0;
        end else if (s) begin
          m_state = ST_RUN;
        end
      end
    endcase
  endtask

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic tick_pulse(input string tag);
    tick = 1'b1;
    model_step(1'b0, 1'b0, 1'b1);
    push_model();
    @(negedge clk);
    tick = 1'b0;
    sb_check(tag);
  endtask

  task automatic idle_check(input string tag);
    m_wrap = 1'b0;
    push_model();
    @(negedge clk);
    sb_check(tag);
  endtask

  // Press keys for 'hold' cycles. The press pulse appears DB+2 edges after the
  // keys go low and the FSM acts one edge later; the optional tick is placed
  // on that same edge.
  task automatic press_keys(input bit s, input bit c, input bit t,
                            input int hold, input string tag);
    if (s) key_start_n = 1'b0;
    if (c) key_clear_n = 1'b0;
    repeat (DB + 2) @(negedge clk);
    m_wrap = 1'b0;
    push_model();
    sb_check({tag, "_pre"});
    if (t) tick = 1'b1;
    model_step(s, c, t);
    push_model();
    @(negedge clk);
    tick = 1'b0;
    sb_check(tag);
    repeat (hold - (DB + 3)) @(negedge clk);
    key_start_n = 1'b1;
    key_clear_n = 1'b1;
    repeat (DB + 4) @(negedge clk);
    m_wrap = 1'b0;
    push_model();
    sb_check({tag, "_rel"});
  endtask

  // ---------------- running-edge monitor for the bounce test ----------------
  bit mon_en   = 1'b0;
  bit prev_run = 1'b0;
  int run_rises = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (running && !prev_run) run_rises++;
      prev_run = running;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    @(negedge clk);
    push_model();
    sb_check("reset_state");
    @(negedge clk);
    rst = 1'b0;

    // start, a few seconds, then reset mid-run
    press_keys(1'b1, 1'b0, 1'b0, 10, "start1");
    for (int i = 0; i < 3; i++) tick_pulse("tick_pre_rst");
    rst = 1'b1;
    m_state = ST_IDLE;
    m_secs  = 0;
    m_wrap  = 1'b0;
    push_model();
    @(negedge clk);
    sb_check("rst_mid_run");
    @(negedge clk);
    rst = 1'b0;
    idle_check("after_rst");

    // start and count 12 s, ticks spaced out by an idle cycle
    press_keys(1'b1, 1'b0, 1'b0, 10, "start2");
    for (int i = 0; i < 12; i++) begin
      tick_pulse("count12");
      @(negedge clk);
    end
    check_eq("shows_00_12", obs_vec(), {ST_RUN, 1'b1, 1'b0, 5'd0, 5'd0, 5'd1, 5'd2});

    // pause, ignored ticks, clear
    press_keys(1'b1, 1'b0, 1'b0, 10, "pause");
    for (int i = 0; i < 5; i++) tick_pulse("tick_in_pause");
    press_keys(1'b0, 1'b1, 1'b0, 10, "clear_pause");
    tick_pulse("tick_in_idle");

    // clear while running is ignored; counting continues
    press_keys(1'b1, 1'b0, 1'b0, 10, "start3");
    for (int i = 0; i < $urandom_range(2, 6); i++) tick_pulse("count_rand");
    press_keys(1'b0, 1'b1, 1'b0, 10, "clear_in_run");
    tick_pulse("count_after_clr");

    // tick together with a start press in RUN, then start+clear in PAUSE
    press_keys(1'b1, 1'b0, 1'b1, 10, "tick_and_start");
    press_keys(1'b1, 1'b1, 1'b0, 10, "start_clear_pause");
    press_keys(1'b1, 1'b1, 1'b0, 10, "start_clear_idle");

    // bounce then hold: exactly one RUN entry, release silent
    mon_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      key_start_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (2) @(negedge clk);
    end
    key_start_n = 1'b1;
    idle_check("after_bounce");
    press_keys(1'b1, 1'b0, 1'b0, 100, "hold");
    repeat (20) @(negedge clk);
    mon_en = 1'b0;
    check_eq("run_entries", W'(run_rises), W'(1));

    // rollover: 3599 ticks to 59:59, one more wraps
    for (int i = 0; i < 3599; i++) tick_pulse("roll_count");
    check_eq("shows_59_59", obs_vec(), {ST_RUN, 1'b1, 1'b0, 5'd5, 5'd9, 5'd5, 5'd9});
    tick_pulse("rollover");
    check_eq("wrap_word", obs_vec(), {ST_RUN, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 5'd0});
    idle_check("wrap_drop");
    tick_pulse("after_wrap");

    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL queue_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
